// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision types and constants for the FP datapath stages.
package fp_pkg;

   localparam int unsigned EXP_W  = 8;
   localparam int unsigned MANT_W = 23;
   localparam int unsigned FP_W   = 1 + EXP_W + MANT_W;
   localparam int unsigned SIG_W  = MANT_W + 1;
   localparam int unsigned PROD_W = 2 * SIG_W;
   localparam int unsigned E_W    = 10;
   localparam int unsigned EXP_BIAS = 127;

   localparam logic [FP_W-1:0]  QNAN    = 32'h7FC0_0000;
   localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [MANT_W-1:0] mant;
   } fp_t;

   typedef enum logic [3:0] {
      GET_A, GET_B, UNPACK, SPECIAL, MULT, NORM, ROUND, PACK, PUT_Z
   } fp_mul_state_t;

endpackage

// File: rtl/fp_round_pack.sv
// Combinational round + overflow/underflow pack of a normalised mantissa into IEEE SP.
// FP_MUL_ROUND_NEAREST_EN selects round-to-nearest-even; otherwise the result is truncated.
module fp_round_pack
   import fp_pkg::*;
(
   input  logic                  i_sign,
   input  logic signed [E_W-1:0] i_e,
   input  logic [MANT_W-1:0]     i_m,
   input  logic                  i_g,
   input  logic                  i_s,
   output logic [FP_W-1:0]       o_z
);

   localparam int unsigned SUM_W = MANT_W + 1;
   localparam logic signed [E_W-1:0] E_OVF  = 10'sd255;
   localparam logic signed [E_W-1:0] E_ZERO = 10'sd0;

   logic                  w_inc;
   logic [SUM_W-1:0]      w_sum;
   logic signed [E_W-1:0] w_e;

`ifdef FP_MUL_ROUND_NEAREST_EN
   assign w_inc = i_g & (i_s | i_m[0]);
`else
   logic w_unused_gs;
   assign w_unused_gs = i_g ^ i_s;
   assign w_inc       = 1'b0;
`endif

   // Mantissa carry-out leaves m=0 and bumps the exponent
   assign w_sum = {1'b0, i_m} + SUM_W'(w_inc);
   assign w_e   = i_e + E_W'(w_sum[MANT_W]);

   always_comb begin
      o_z = {i_sign, w_e[EXP_W-1:0], w_sum[MANT_W-1:0]};
      if (w_e >= E_OVF) begin
         o_z = {i_sign, EXP_INF, MANT_W'(0)};
      end else if (w_e <= E_ZERO) begin
         o_z = {i_sign, (FP_W-1)'(0)};
      end
   end

endmodule

// File: rtl/fp_multiplier.sv
// Multi-cycle IEEE SP multiplier with stb/ack handshakes, one product in flight.
// FP_MUL_ROUND_NEAREST_EN enables round-to-nearest-even (default build truncates).
module fp_multiplier
   import fp_pkg::*;
#(
   parameter logic [31:0] NAN_VALUE = QNAN
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] a_in,
   input  logic        a_stb,
   input  logic [31:0] b_in,
   input  logic        b_stb,
   input  logic        z_ack,
   output logic        a_ack,
   output logic        b_ack,
   output logic [31:0] z_out,
   output logic        z_stb
);

   fp_mul_state_t r_state, w_state_nxt;
   logic r_a_ack, r_b_ack, r_z_stb;
   logic w_a_ack_nxt, w_b_ack_nxt, w_z_stb_nxt;
   logic [FP_W-1:0] r_z_out, r_res;

   fp_t                   r_a, r_b;
   logic                  r_sign, r_za, r_zb;
   logic [EXP_W-1:0]      r_ea, r_eb;
   logic [SIG_W-1:0]      r_ma, r_mb;
   logic [PROD_W-1:0]     r_p;
   logic signed [E_W-1:0] r_e;
   logic [MANT_W-1:0]     r_m;
   logic                  r_g, r_s;

   logic w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_special_hit;
   logic [FP_W-1:0] w_special_z, w_rp_z;

   assign a_ack = r_a_ack;
   assign b_ack = r_b_ack;
   assign z_stb = r_z_stb;
   assign z_out = r_z_out;

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= GET_A;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         GET_A:   if (a_stb && r_a_ack) w_state_nxt = GET_B;
         GET_B:   if (b_stb && r_b_ack) w_state_nxt = UNPACK;
         UNPACK:  w_state_nxt = SPECIAL;
         SPECIAL: w_state_nxt = w_special_hit ? PUT_Z : MULT;
         MULT:    w_state_nxt = NORM;
         NORM:    w_state_nxt = ROUND;
         ROUND:   w_state_nxt = PACK;
         PACK:    w_state_nxt = PUT_Z;
         PUT_Z:   if (z_ack && r_z_stb) w_state_nxt = GET_A;
         default: w_state_nxt = GET_A;
      endcase
   end

   // Handshake outputs are registered copies of the state being entered
   always_comb begin
      w_a_ack_nxt = (w_state_nxt == GET_A);
      w_b_ack_nxt = (w_state_nxt == GET_B);
      w_z_stb_nxt = (w_state_nxt == PUT_Z);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_ack <= 1'b0;
         r_b_ack <= 1'b0;
         r_z_stb <= 1'b0;
      end else begin
         r_a_ack <= w_a_ack_nxt;
         r_b_ack <= w_b_ack_nxt;
         r_z_stb <= w_z_stb_nxt;
      end
   end

   assign w_nan_a = (r_a.exp == EXP_INF) && (r_a.mant != '0);
   assign w_nan_b = (r_b.exp == EXP_INF) && (r_b.mant != '0);
   assign w_inf_a = (r_a.exp == EXP_INF) && (r_a.mant == '0);
   assign w_inf_b = (r_b.exp == EXP_INF) && (r_b.mant == '0);

   // Special-case detection in priority order: NaN, Inf, zero
   always_comb begin
      w_special_hit = 1'b1;
      w_special_z   = NAN_VALUE;
      if (w_nan_a || w_nan_b || (w_inf_a && r_zb) || (w_inf_b && r_za)) begin
         w_special_z = NAN_VALUE;
      end else if (w_inf_a || w_inf_b) begin
         w_special_z = {r_sign, EXP_INF, MANT_W'(0)};
      end else if (r_za || r_zb) begin
         w_special_z = {r_sign, (FP_W-1)'(0)};
      end else begin
         w_special_hit = 1'b0;
      end
   end

   fp_round_pack u_round_pack (
      .i_sign (r_sign),
      .i_e    (r_e),
      .i_m    (r_m),
      .i_g    (r_g),
      .i_s    (r_s),
      .o_z    (w_rp_z)
   );

   // Datapath; reset discards any latched operands
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a <= '0;  r_b <= '0;  r_sign <= 1'b0;
         r_za <= 1'b0; r_zb <= 1'b0;
         r_ea <= '0; r_eb <= '0; r_ma <= '0; r_mb <= '0;
         r_p <= '0;  r_e <= '0;  r_m <= '0;  r_g <= 1'b0; r_s <= 1'b0;
         r_res <= '0; r_z_out <= '0;
      end else begin
         case (r_state)
            GET_A: if (a_stb && r_a_ack) r_a <= a_in;
            GET_B: if (b_stb && r_b_ack) r_b <= b_in;
            UNPACK: begin
               r_sign <= r_a.sign ^ r_b.sign;
               r_ea   <= r_a.exp;
               r_eb   <= r_b.exp;
               r_za   <= (r_a.exp == '0);
               r_zb   <= (r_b.exp == '0);
               r_ma   <= (r_a.exp == '0) ? '0 : {1'b1, r_a.mant};
               r_mb   <= (r_b.exp == '0) ? '0 : {1'b1, r_b.mant};
            end
            SPECIAL: if (w_special_hit) r_z_out <= w_special_z;
            MULT: begin
               r_p <= PROD_W'(r_ma) * PROD_W'(r_mb);
               r_e <= E_W'(r_ea) + E_W'(r_eb) - E_W'(EXP_BIAS);
            end
            NORM: begin
               if (r_p[PROD_W-1]) begin
                  r_m <= r_p[46:24];
                  r_g <= r_p[23];
                  r_s <= |r_p[22:0];
                  r_e <= r_e + E_W'(1);
               end else begin
                  r_m <= r_p[45:23];
                  r_g <= r_p[22];
                  r_s <= |r_p[21:0];
               end
            end
            ROUND: r_res <= w_rp_z;
            PACK:  r_z_out <= r_res;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_multiplier.sv
// Scoreboard bench for fp_multiplier: handshakes, latency, specials and mid-operation reset.
module tb_fp_multiplier;

   typedef struct {
      logic [31:0] val;
      int          lat;
      int          bcyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] a_in = '0, b_in = '0;
   logic        a_stb = 1'b0, b_stb = 1'b0, z_ack = 1'b0;
   logic        a_ack, b_ack, z_stb;
   logic [31:0] z_out;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   last_bcyc = 0;
   exp_t sb_q[$];

   localparam int LAT_N = 7;
   localparam int LAT_S = 3;

`ifdef FP_MUL_ROUND_NEAREST_EN
   localparam logic [31:0] TIE_EXP = 32'h3FC0_0002;
`else
   localparam logic [31:0] TIE_EXP = 32'h3FC0_0001;
`endif

   fp_multiplier dut (
      .clk   (clk),
      .rst   (rst),
      .a_in  (a_in),
      .a_stb (a_stb),
      .b_in  (b_in),
      .b_stb (b_stb),
      .z_ack (z_ack),
      .a_ack (a_ack),
      .b_ack (b_ack),
      .z_out (z_out),
      .z_stb (z_stb)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Drive one A/B pair (caller is at a negedge) and push the expected result
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_z,
                        input int lat, input int da, input int db);
      int   t;
      exp_t e;
      a_stb = 1'b0;
      b_stb = 1'b0;
      for (int i = 0; i < da; i++) begin
         n_checks++;
         if (b_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL b_ack_before_a: got %b want 0", b_ack);
         end
         @(negedge clk);
      end
      a_in = a; a_stb = 1'b1; t = 0;
      while (a_ack !== 1'b1 && t < 100) begin @(negedge clk); t++; end
      if (a_ack !== 1'b1) begin
         n_checks++; n_fail++;
         $display("FAIL a_ack_timeout: got %b want 1", a_ack);
         a_stb = 1'b0;
         return;
      end
      @(negedge clk);
      a_stb = 1'b0; a_in = 32'hDEAD_BEEF;
      for (int i = 0; i < db; i++) @(negedge clk);
      b_in = b; b_stb = 1'b1; t = 0;
      while (b_ack !== 1'b1 && t < 100) begin @(negedge clk); t++; end
      if (b_ack !== 1'b1) begin
         n_checks++; n_fail++;
         $display("FAIL b_ack_timeout: got %b want 1", b_ack);
         b_stb = 1'b0;
         return;
      end
      e.val = exp_z; e.lat = lat; e.bcyc = cyc;
      last_bcyc = cyc;
      sb_q.push_back(e);
      @(negedge clk);
      b_stb = 1'b0; b_in = 32'hDEAD_BEEF;
   endtask

   // Wait for z_stb, compare against the scoreboard, hold z_ack off for zdly cycles
   task automatic collect(input int zdly);
      int          t;
      exp_t        e;
      logic [31:0] held;
      t = 0;
      while (z_stb !== 1'b1 && t < 100) begin @(negedge clk); t++; end
      n_checks++;
      if (z_stb !== 1'b1) begin
         n_fail++;
         $display("FAIL z_stb_timeout: got %b want 1", z_stb);
         if (sb_q.size() > 0) void'(sb_q.pop_front());
         return;
      end
      if (sb_q.size() == 0) begin
         n_fail++;
         $display("FAIL unexpected_result: got %h with empty scoreboard", z_out);
         return;
      end
      e = sb_q.pop_front();
      if (z_out !== e.val) begin
         n_fail++;
         $display("FAIL z_out: got %h want %h", z_out, e.val);
      end
      n_checks++;
      if (cyc - e.bcyc !== e.lat) begin
         n_fail++;
         $display("FAIL latency: got %0d want %0d", cyc - e.bcyc, e.lat);
      end
      held = z_out;
      for (int i = 0; i < zdly; i++) begin
         @(negedge clk);
         n_checks++;
         if (z_stb !== 1'b1 || z_out !== held || a_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL hold: z_stb=%b z_out=%h a_ack=%b want 1 %h 0", z_stb, z_out, a_ack, held);
         end
      end
      z_ack = 1'b1;
      @(negedge clk);
      z_ack = 1'b0;
      n_checks++;
      if (z_stb !== 1'b0 || a_ack !== 1'b1) begin
         n_fail++;
         $display("FAIL release: z_stb=%b a_ack=%b want 0 1", z_stb, a_ack);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (a_ack !== 1'b0 || b_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_acks: a_ack=%b b_ack=%b want 0 0", a_ack, b_ack);
      end
      n_checks++;
      if (z_stb !== 1'b0 || z_out !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_z: z_stb=%b z_out=%h want 0 00000000", z_stb, z_out);
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (a_ack !== 1'b1 || b_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_get_a: a_ack=%b b_ack=%b want 1 0", a_ack, b_ack);
      end
   endtask

   task automatic test_normal;
      issue(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, LAT_N, 0, 0); collect(0);
      issue(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, LAT_N, 0, 0); collect(0);
      issue(32'hC000_0000, 32'h3F00_0000, 32'hBF80_0000, LAT_N, 0, 0); collect(0);
      issue(32'h3F80_0001, 32'h3FC0_0000, TIE_EXP,       LAT_N, 0, 0); collect(0);
   endtask

   task automatic test_special;
      issue(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, LAT_S, 0, 0); collect(0);
      issue(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, LAT_S, 0, 0); collect(0);
      issue(32'h7FC1_2345, 32'h3F80_0000, 32'h7FC0_0000, LAT_S, 0, 0); collect(0);
      issue(32'h0000_0000, 32'hC040_0000, 32'h8000_0000, LAT_S, 0, 0); collect(0);
      issue(32'h0000_0001, 32'h4000_0000, 32'h0000_0000, LAT_S, 0, 0); collect(0);
      issue(32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, LAT_N, 0, 0); collect(0);
      issue(32'h0080_0000, 32'h0080_0000, 32'h0000_0000, LAT_N, 0, 0); collect(0);
   endtask

   task automatic test_handshake;
      z_ack = 1'b1;
      issue(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, LAT_N, 5, 5);
      z_ack = 1'b0;
      collect(10);
   endtask

   task automatic test_back_to_back;
      int first;
      issue(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, LAT_N, 0, 0); collect(0);
      first = last_bcyc;
      issue(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, LAT_N, 0, 0); collect(0);
      n_checks++;
      if (last_bcyc - first !== 9) begin
         n_fail++;
         $display("FAIL throughput: got %0d cycles want 9", last_bcyc - first);
      end
   endtask

   task automatic test_reset_mid;
      issue(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, LAT_N, 0, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      sb_q.delete();
      n_checks++;
      if (z_stb !== 1'b0 || z_out !== 32'h0 || a_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: z_stb=%b z_out=%h a_ack=%b want 0 00000000 0", z_stb, z_out, a_ack);
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (a_ack !== 1'b1 || z_stb !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_get_a: a_ack=%b z_stb=%b want 1 0", a_ack, z_stb);
      end
      issue(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, LAT_N, 0, 0); collect(0);
   endtask

   initial begin
      test_reset();
      test_normal();
      test_special();
      test_handshake();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_multiplier.md
Name: fp_multiplier

Overview:
- Multi-cycle IEEE-754 single-precision multiplier for the matrix-multiplier datapath.
- Sits directly upstream of the FP adder/accumulator: z_out/z_stb feed the adder's a_in/a_stb.
- Uses the same stb/ack operand/result handshake as the handshaked adder, so stages chain without glue.
- One product in flight at a time; FSM-sequenced.

Parameters:
- NAN_VALUE, 32'h7FC0_0000, canonical quiet NaN emitted for any invalid result.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- a_in  in  32  operand A, IEEE SP.
- a_stb  in  1  a_in valid.
- b_in  in  32  operand B, IEEE SP.
- b_stb  in  1  b_in valid.
- z_ack  in  1  downstream accepts z_out.
- a_ack  out  1  A accepted this cycle when a_stb & a_ack.
- b_ack  out  1  B accepted this cycle when b_stb & b_ack.
- z_out  out  32  product, IEEE SP.
- z_stb  out  1  z_out valid; held until z_ack.

Behaviour:
- Reset values: a_ack=0, b_ack=0, z_stb=0, z_out=0; FSM enters GET_A.
- rst mid-operation: abort and discard latched operands; z_stb drops on the next edge.
- States: GET_A -> GET_B -> UNPACK -> SPECIAL -> MULT -> NORM -> ROUND -> PACK -> PUT_Z -> GET_A.
- GET_A: a_ack=1. On a_stb, latch a_in, clear a_ack, go GET_B.
- GET_B: b_ack=1. On b_stb, latch b_in, clear b_ack, go UNPACK.
- Acks are registered and are never high in any other state.
- UNPACK: split sign/exp/mantissa and form sign = sa^sb.
  - Exponent 0 (zero or denormal) is flagged as zero; denormals are flushed.
  - Nonzero exponent: prepend hidden 1 to form a 24-bit mantissa.
- SPECIAL, priority order; any hit writes z_out and jumps to PUT_Z, otherwise go MULT:
  - Either input NaN, or Inf x zero -> NAN_VALUE.
  - Inf x nonzero -> {sign, 8'hFF, 23'h0}.
  - Zero x finite -> {sign, 31'h0}.
- MULT: p[47:0] = ma*mb (24x24, one cycle); e = ea + eb - 127, held as 10-bit signed.
- NORM:
  - If p[47]: m = p[46:24], g = p[23], s = |p[22:0], e = e+1.
  - Else: m = p[45:23], g = p[22], s = |p[21:0].
- ROUND: rounding rule per Optional Feature. A mantissa carry-out sets m=0 and e = e+1.
- PACK, from the final exponent:
  - e >= 255 -> {sign, 8'hFF, 23'h0} (overflow).
  - e <= 0 -> {sign, 31'h0} (underflow flushed to zero).
  - Otherwise {sign, e[7:0], m}.
- PUT_Z: z_stb=1 and z_out stable until z_ack; the handshake cycle clears z_stb and goes GET_A.
  - z_ack while z_stb=0 is ignored.
- Latency, with the B handshake in cycle N:
  - Normal path: z_stb=1 in cycle N+7.
  - Special path: z_stb=1 in cycle N+3.
- Throughput: one result per 9 cycles minimum, with zero-wait a/b/z partners.

Optional Feature:
- Macro FP_MUL_ROUND_NEAREST_EN.
- Defined: round-to-nearest-even. Increment m when g & (s | m[0]).
- Undefined: truncate (g and s ignored), matching the adder's truncation behaviour.
- Latency and state sequence are identical in both builds.

Decomposition:
- Shared package fp_pkg holds:
  - EXP_BIAS=127, EXP_W=8, MANT_W=23.
  - QNAN constant and EXP_INF=8'hFF.
  - typedef fp_t as a struct of sign/exp/mant.
  - State enum typedef fp_mul_state_t.
- One natural sub-module, fp_round_pack: combinational round + overflow/underflow pack.
  - Inputs: sign, 10-bit e, m, g, s.
  - Output: 32-bit result.
  - Reusable by the adder later.

Test Plan:
- 0x40000000 x 0x40400000 (2x3) -> z_out=0x40C00000, z_stb in cycle N+7.
- 0x3FC00000 x 0x3FC00000 (1.5x1.5, p[47] path) -> 0x40100000. 0xC0000000 x 0x3F000000 -> 0xBF800000.
- 0x3F800001 x 0x3FC00000 (tie case) -> 0x3FC00002 with FP_MUL_ROUND_NEAREST_EN; 0x3FC00001 without.
- Specials:
  - 0x7F800000 x 0x00000000 -> 0x7FC00000.
  - 0xFF800000 x 0x40000000 -> 0xFF800000.
  - 0x7F000000 x 0x40000000 -> 0x7F800000 (overflow).
  - 0x00800000 x 0x00800000 -> 0x00000000 (underflow).
  - Special-path results appear with z_stb in cycle N+3.
- Handshake:
  - a_stb and b_stb delayed 5 cycles each -> no ack until stb; b_ack never high before A is accepted.
  - z_ack withheld 10 cycles -> z_out/z_stb stable, no new a_ack.
- Assert rst in MULT state -> next cycle z_stb=0, a_ack=1 in GET_A, z_out=0. A following 2x3 gives 0x40C00000.
